// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational alu among NUM_REQ requesters.
// A grant is issued only when the single registered response slot is free
// (empty, or being drained this cycle). The granted requester's operands
// drive the alu, and the alu result is captured into the slot together with
// the winner's index.
//
// Optional build macro ALU_ARB_FIXED_PRIO_EN: when defined, arbitration is
// fixed priority (lowest index wins) and the round-robin pointer is removed.
// When undefined (default), arbitration is round-robin starting at rr_q.

package imhotep_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } op_alu_e;

endpackage

module alu_arbiter
  import imhotep_pkg::*;
#(
  parameter int NUM_REQ = 2,
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ*XLEN-1:0]  req_a_i,
  input  logic [NUM_REQ*XLEN-1:0]  req_b_i,
  input  logic [NUM_REQ*XLEN-1:0]  req_pc_i,
  input  op_alu_e [NUM_REQ-1:0]    req_op_i,
  output logic [XLEN-1:0]          alu_a_o,
  output logic [XLEN-1:0]          alu_b_o,
  output logic [XLEN-1:0]          alu_pc_o,
  output op_alu_e                  alu_op_o,
  input  logic [XLEN-1:0]          alu_out_i,
  input  logic [XLEN-1:0]          alu_pc_inc_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [IDW-1:0]           rsp_id_o,
  output logic [XLEN-1:0]          rsp_data_o,
  output logic [XLEN-1:0]          rsp_pc_inc_o
);

  logic            rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [XLEN-1:0] rsp_data_q, rsp_data_d;
  logic [XLEN-1:0] rsp_pc_inc_q, rsp_pc_inc_d;

`ifndef ALU_ARB_FIXED_PRIO_EN
  logic [IDW-1:0]  rr_q, rr_d;
`endif

  logic            slot_free;
  logic            gnt_found;
  logic            gnt_fire;
  logic [IDW-1:0]  gnt_idx;
  int              cand_w;
  logic [IDW-1:0]  cand;

  // The slot can take a new result if it is empty or its content leaves this cycle.
  assign slot_free = !rsp_valid_q || rsp_ready_i;

  // Search for the first valid requester, starting at rr_q (or index 0 in fixed priority).
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand_w    = 0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      cand_w = k;
`else
      cand_w = int'(rr_q) + k;
      if (cand_w >= NUM_REQ) begin
        cand_w = cand_w - NUM_REQ;
      end
`endif
      cand = cand_w[IDW-1:0];
      if (!gnt_found && req_valid_i[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // Gating with rst_ni keeps every grant low while reset is asserted.
  assign gnt_fire    = rst_ni && slot_free && gnt_found;
  assign req_ready_o = gnt_fire ? (NUM_REQ'(1) << gnt_idx) : '0;

  // Steer the granted requester onto the alu; idle value is zero operands with ADD.
  always_comb begin
    alu_a_o  = '0;
    alu_b_o  = '0;
    alu_pc_o = '0;
    alu_op_o = ALU_ADD;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_fire && (gnt_idx == IDW'(i))) begin
        alu_a_o  = req_a_i[i*XLEN +: XLEN];
        alu_b_o  = req_b_i[i*XLEN +: XLEN];
        alu_pc_o = req_pc_i[i*XLEN +: XLEN];
        alu_op_o = req_op_i[i];
      end
    end
  end

  // Response slot: refill on a grant, otherwise empty it when drained; payload holds when not refilled.
  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    rsp_pc_inc_d = rsp_pc_inc_q;
    if (gnt_fire) begin
      rsp_valid_d  = 1'b1;
      rsp_id_d     = gnt_idx;
      rsp_data_d   = alu_out_i;
      rsp_pc_inc_d = alu_pc_inc_i;
    end else if (rsp_ready_i) begin
      rsp_valid_d  = 1'b0;
    end
  end

  // Response slot registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_data_q   <= '0;
      rsp_pc_inc_q <= '0;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_pc_inc_q <= rsp_pc_inc_d;
    end
  end

`ifndef ALU_ARB_FIXED_PRIO_EN
  // Pointer moves just past the winner so the winner has lowest priority next time.
  always_comb begin
    rr_d = rr_q;
    if (gnt_fire) begin
      if (gnt_idx == IDW'(NUM_REQ - 1)) begin
        rr_d = '0;
      end else begin
        rr_d = gnt_idx + IDW'(1);
      end
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end
`endif

  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_id_o     = rsp_id_q;
  assign rsp_data_o   = rsp_data_q;
  assign rsp_pc_inc_o = rsp_pc_inc_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter with two requesters and a behavioural alu.
// Requests are queued per requester and driven by a handshake driver;
// expected responses go into a scoreboard queue that a monitor checks.
module tb_alu_arbiter;
  import imhotep_pkg::*;

  localparam int NR = 2;

  typedef struct packed {
    op_alu_e     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc;
  } req_t;

  typedef struct packed {
    logic [31:0] id;
    logic [31:0] data;
    logic [31:0] pcinc;
  } exp_t;

  logic                 clk_i = 1'b0;
  logic                 rst_ni;
  logic [NR-1:0]        req_valid_i;
  logic [NR-1:0]        req_ready_o;
  logic [NR*32-1:0]     req_a_i, req_b_i, req_pc_i;
  op_alu_e [NR-1:0]     req_op_i;
  logic [31:0]          alu_a_o, alu_b_o, alu_pc_o;
  op_alu_e              alu_op_o;
  logic [31:0]          alu_out, alu_pc_inc;
  logic                 rsp_valid_o, rsp_ready_i;
  logic [0:0]           rsp_id_o;
  logic [31:0]          rsp_data_o, rsp_pc_inc_o;

  int   n_tests = 0;
  int   n_fail  = 0;
  req_t drv_q[NR][$];
  exp_t exp_q[$];
  exp_t mon_e;
  logic [NR-1:0] drv_fire;
  int   cyc;

  always #5 clk_i = ~clk_i;

  alu_arbiter #(.NUM_REQ(NR)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_a_i      (req_a_i),
    .req_b_i      (req_b_i),
    .req_pc_i     (req_pc_i),
    .req_op_i     (req_op_i),
    .alu_a_o      (alu_a_o),
    .alu_b_o      (alu_b_o),
    .alu_pc_o     (alu_pc_o),
    .alu_op_o     (alu_op_o),
    .alu_out_i    (alu_out),
    .alu_pc_inc_i (alu_pc_inc),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_id_o     (rsp_id_o),
    .rsp_data_o   (rsp_data_o),
    .rsp_pc_inc_o (rsp_pc_inc_o)
  );

  // behavioural stand-in for the external alu
  always_comb begin
    case (alu_op_o)
      ALU_ADD: alu_out = alu_a_o + alu_b_o;
      ALU_SUB: alu_out = alu_a_o - alu_b_o;
      ALU_AND: alu_out = alu_a_o & alu_b_o;
      ALU_OR:  alu_out = alu_a_o | alu_b_o;
      ALU_XOR: alu_out = alu_a_o ^ alu_b_o;
      default: alu_out = 32'd0;
    endcase
  end
  assign alu_pc_inc = alu_pc_o + 32'd4;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_req(input int r, input op_alu_e op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] pc);
    req_t t;
    t.op = op; t.a = a; t.b = b; t.pc = pc;
    drv_q[r].push_back(t);
  endtask

  task automatic push_exp(input int id, input logic [31:0] data, input logic [31:0] pcinc);
    exp_t e;
    e.id = 32'(id); e.data = data; e.pcinc = pcinc;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string name, input int budget, output int cycles);
    cycles = 0;
    while ((exp_q.size() != 0 || drv_q[0].size() != 0 || drv_q[1].size() != 0) && cycles < budget) begin
      step();
      cycles++;
    end
    n_tests++;
    if (exp_q.size() != 0 || drv_q[0].size() != 0 || drv_q[1].size() != 0) begin
      n_fail++;
      $display("FAIL %s_timeout: %0d responses pending after %0d cycles, required 0",
               name, exp_q.size(), cycles);
      exp_q.delete();
      drv_q[0].delete();
      drv_q[1].delete();
    end
  endtask

  // driver: hold each request until its handshake, then present the next one
  initial begin
    req_valid_i = '0;
    req_a_i = '0; req_b_i = '0; req_pc_i = '0;
    req_op_i = {ALU_ADD, ALU_ADD};
    forever begin
      @(negedge clk_i);
      drv_fire = req_valid_i & req_ready_o;
      @(posedge clk_i);
      #2;
      for (int i = 0; i < NR; i++) begin
        if (drv_fire[i] && drv_q[i].size() > 0) void'(drv_q[i].pop_front());
        if (drv_q[i].size() > 0) begin
          req_valid_i[i]        = 1'b1;
          req_a_i[i*32 +: 32]   = drv_q[i][0].a;
          req_b_i[i*32 +: 32]   = drv_q[i][0].b;
          req_pc_i[i*32 +: 32]  = drv_q[i][0].pc;
          req_op_i[i]           = drv_q[i][0].op;
        end else begin
          req_valid_i[i]        = 1'b0;
          req_a_i[i*32 +: 32]   = 32'd0;
          req_b_i[i*32 +: 32]   = 32'd0;
          req_pc_i[i*32 +: 32]  = 32'd0;
          req_op_i[i]           = ALU_ADD;
        end
      end
    end
  end

  // monitor: every accepted response is compared against the scoreboard head
  always @(negedge clk_i) begin
    if (rst_ni && rsp_valid_o && rsp_ready_i) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rsp_unexpected: got id %0d data 0x%0h, required no response",
                 rsp_id_o, rsp_data_o);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_id", 64'(rsp_id_o), 64'(mon_e.id));
        check("rsp_data", 64'(rsp_data_o), 64'(mon_e.data));
        check("rsp_pc_inc", 64'(rsp_pc_inc_o), 64'(mon_e.pcinc));
      end
    end
  end

  initial begin
    rst_ni      = 1'b0;
    rsp_ready_i = 1'b0;
    repeat (3) step();
    check("reset_rsp_valid", 64'(rsp_valid_o), 64'd0);
    check("reset_rsp_data", 64'(rsp_data_o), 64'd0);
    check("reset_req_ready", 64'(req_ready_o), 64'd0);
    rst_ni = 1'b1;
    step();

    // single request, one-cycle latency then empty slot
    rsp_ready_i = 1'b1;
    push_req(0, ALU_ADD, 32'd1, 32'd4, 32'h100);
    push_exp(0, 32'd5, 32'h104);
    step();
    check("single_valid", 64'(rsp_valid_o), 64'd1);
    check("single_id", 64'(rsp_id_o), 64'd0);
    check("single_data", 64'(rsp_data_o), 64'd5);
    step();
    check("single_empty_after", 64'(rsp_valid_o), 64'd0);
    wait_drain("single", 20, cyc);

    // idle: alu inputs parked, nothing granted
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      check("idle_alu_op", 64'(alu_op_o), 64'(ALU_ADD));
      check("idle_alu_a", 64'(alu_a_o), 64'd0);
      check("idle_alu_b", 64'(alu_b_o | alu_pc_o), 64'd0);
      check("idle_rsp_valid", 64'(rsp_valid_o), 64'd0);
      check("idle_req_ready", 64'(req_ready_o), 64'd0);
      step();
    end

    // pointer held at 1 across idle: requester 1 wins the first tie
    push_req(0, ALU_OR, 32'hF0, 32'h0F, 32'h700);
    push_req(1, ALU_XOR, 32'hFF, 32'h0F, 32'h800);
`ifdef ALU_ARB_FIXED_PRIO_EN
    push_exp(0, 32'hFF, 32'h704);
    push_exp(1, 32'hF0, 32'h804);
`else
    push_exp(1, 32'hF0, 32'h804);
    push_exp(0, 32'hFF, 32'h704);
`endif
    wait_drain("idle_rr", 20, cyc);

    // single request from requester 1 returns the pointer to 0
    push_req(1, ALU_ADD, 32'h20, 32'h22, 32'h900);
    push_exp(1, 32'h42, 32'h904);
    wait_drain("single1", 20, cyc);

    // contention with pointer at 0: back-to-back id0 then id1
    push_req(0, ALU_SUB, 32'd5, 32'd4, 32'h300);
    push_req(1, ALU_AND, 32'h0C, 32'h06, 32'h400);
    push_exp(0, 32'd1, 32'h304);
    push_exp(1, 32'h04, 32'h404);
    step();
    check("cont_first_id", 64'(rsp_id_o), 64'd0);
    check("cont_first_data", 64'(rsp_data_o), 64'd1);
    step();
    check("cont_second_valid", 64'(rsp_valid_o), 64'd1);
    check("cont_second_id", 64'(rsp_id_o), 64'd1);
    check("cont_second_data", 64'(rsp_data_o), 64'h04);
    wait_drain("contention", 20, cyc);

    // backpressure: slot holds, no grants, then drain and refill in one cycle
    rsp_ready_i = 1'b0;
    push_req(0, ALU_XOR, 32'hA5, 32'h0F, 32'h200);
    push_req(1, ALU_OR, 32'h30, 32'h03, 32'h300);
    push_exp(0, 32'hAA, 32'h204);
    push_exp(1, 32'h33, 32'h304);
    step();
    check("bp_first_valid", 64'(rsp_valid_o), 64'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      check("bp_req_ready", 64'(req_ready_o), 64'd0);
      check("bp_hold_data", 64'(rsp_data_o), 64'hAA);
      check("bp_hold_valid", 64'(rsp_valid_o), 64'd1);
      step();
    end
    rsp_ready_i = 1'b1;
    step();
    check("bp_refill_valid", 64'(rsp_valid_o), 64'd1);
    check("bp_refill_id", 64'(rsp_id_o), 64'd1);
    check("bp_refill_data", 64'(rsp_data_o), 64'h33);
    wait_drain("backpressure", 20, cyc);

    // fairness and throughput: both requesters keep six requests queued
    for (int k = 0; k < 6; k++) begin
      push_req(0, ALU_ADD, 32'(k), 32'd10, 32'h1000 + 32'(4 * k));
      push_req(1, ALU_SUB, 32'd100, 32'(k), 32'h2000 + 32'(4 * k));
    end
`ifdef ALU_ARB_FIXED_PRIO_EN
    for (int k = 0; k < 6; k++) push_exp(0, 32'd10 + 32'(k), 32'h1004 + 32'(4 * k));
    for (int k = 0; k < 6; k++) push_exp(1, 32'd100 - 32'(k), 32'h2004 + 32'(4 * k));
`else
    for (int k = 0; k < 6; k++) begin
      push_exp(0, 32'd10 + 32'(k), 32'h1004 + 32'(4 * k));
      push_exp(1, 32'd100 - 32'(k), 32'h2004 + 32'(4 * k));
    end
`endif
    wait_drain("fairness", 60, cyc);
    check("fair_throughput", 64'(cyc <= 13), 64'd1);

    // reset while a response is pending: cleared without a clock edge
    rsp_ready_i = 1'b0;
    push_req(0, ALU_ADD, 32'd7, 32'd8, 32'h500);
    step();
    check("pre_reset_data", 64'(rsp_data_o), 64'd15);
    #3;
    rst_ni = 1'b0;
    #1;
    check("async_reset_valid", 64'(rsp_valid_o), 64'd0);
    check("async_reset_data", 64'(rsp_data_o), 64'd0);
    check("async_reset_pc_inc", 64'(rsp_pc_inc_o), 64'd0);
    push_req(1, ALU_AND, 32'hFF, 32'h3C, 32'h600);
    push_req(0, ALU_SUB, 32'd9, 32'd2, 32'h500);
    step();
    step();
    @(negedge clk_i);
    check("in_reset_req_ready", 64'(req_ready_o), 64'd0);
    step();
    rst_ni      = 1'b1;
    rsp_ready_i = 1'b1;
    push_exp(0, 32'd7, 32'h504);
    push_exp(1, 32'h3C, 32'h604);
    wait_drain("post_reset", 20, cyc);

    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
